// File: rtl/alu_seq_if.sv
// Handshake bundle between the decode stage and the execute unit.
// Producer drives operands/code and accepts results; the execute unit is the slave.
interface alu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctl;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   modport master (
      output in_valid, alu_ctl, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alu_ctl, op_a, op_b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle RV32I execute unit: single-cycle logic/arith ops, serial
// 1-bit-per-cycle shifter, valid/ready on both sides, result held in DONE.
module alu_seq_exec #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);

   localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b1000, C_SLL = 4'b0001,
                          C_SLT = 4'b0010, C_SLTU = 4'b0011, C_XOR = 4'b0100,
                          C_SRL = 4'b0101, C_SRA = 4'b1101, C_OR = 4'b0110,
                          C_AND = 4'b0111;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [3:0]      ctl_q, ctl_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic            ill_q, ill_d;

   logic [XLEN-1:0] alu_res;
   logic            legal;
   logic            is_shift;
   logic [SHW-1:0]  shamt;

   assign shamt = bus.op_b[SHW-1:0];

   // Single-cycle datapath; shift codes return op_a so shamt=0 completes directly.
   always_comb begin
      alu_res  = '0;
      legal    = 1'b1;
      is_shift = 1'b0;
      unique case (bus.alu_ctl)
         C_ADD:  alu_res = bus.op_a + bus.op_b;
         C_SUB:  alu_res = bus.op_a - bus.op_b;
         C_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
         C_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
         C_XOR:  alu_res = bus.op_a ^ bus.op_b;
         C_OR:   alu_res = bus.op_a | bus.op_b;
         C_AND:  alu_res = bus.op_a & bus.op_b;
         C_SLL, C_SRL, C_SRA: begin
            alu_res  = bus.op_a;
            is_shift = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Next-state: accept in IDLE, shift one bit per SHIFT cycle, hold in DONE until drained.
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      ctl_d   = ctl_q;
      cnt_d   = cnt_q;
      ill_d   = ill_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               ctl_d = bus.alu_ctl;
               ill_d = ~legal;
               cnt_d = shamt;
               res_d = legal ? alu_res : '0;
               if (is_shift && shamt != '0) state_d = SHIFT;
               else                         state_d = DONE;
            end
         end
         SHIFT: begin
            unique case (ctl_q)
               C_SLL:   res_d = {res_q[XLEN-2:0], 1'b0};
               C_SRA:   res_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
               default: res_d = {1'b0, res_q[XLEN-1:1]};
            endcase
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         ctl_q   <= '0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         ctl_q   <= ctl_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) & ~rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.zero      = (state_q == DONE) & (res_q == '0);
   assign bus.illegal   = (state_q == DONE) & ill_q;

endmodule
